// File: rtl/c2f_dma_reader_pkg.sv
// c2f_dma_reader_pkg: shared constants, register indices, word/pointer types and FSM state enum for the C2F DMA reader
package c2f_dma_reader_pkg;
  localparam int SLOT_LOG2 = 4;
  localparam int QW_PER_SLOT = 16;
  localparam int PTR_OFFSET = 2048;
  localparam int SLOT_BYTES_LOG2 = 7;
  localparam int FIFO_AW = $clog2(QW_PER_SLOT);
  localparam logic [7:0] REG_DMA_ENABLE = 8'd1;
  localparam logic [7:0] REG_C2F_BASE = 8'd2;
  localparam logic [7:0] REG_C2F_WRPTR = 8'd3;
  localparam logic [7:0] REG_CHECKSUM_LO = 8'd254;
  localparam logic [7:0] REG_CHECKSUM_HI = 8'd255;
  typedef logic [63:0] word_t;
  typedef logic [SLOT_LOG2-1:0] ptr_t;
  typedef enum logic [2:0] {IDLE, REQ, CPL, UPD, DRAIN} c2f_state_t;
endpackage

// File: rtl/c2f_dma_reader_if.sv
// c2f_dma_reader_if: host regs in, MRd/MWr request handshakes, completion beats in, app stream out, checksum/rd_ptr status out
interface c2f_dma_reader_if;
  import c2f_dma_reader_pkg::*;
  logic dma_reset;
  logic [31:0] c2f_base;
  ptr_t c2f_wr_ptr;
  logic c2f_wr_ptr_valid;
  logic rd_req_valid;
  logic rd_req_ready;
  word_t rd_req_addr;
  word_t cpl_data;
  logic cpl_valid;
  word_t c2f_data;
  logic c2f_valid;
  logic c2f_ready;
  logic wr_req_valid;
  logic wr_req_ready;
  word_t wr_req_addr;
  word_t wr_req_data;
  word_t checksum;
  ptr_t rd_ptr;
  modport master(
    input dma_reset, c2f_base, c2f_wr_ptr, c2f_wr_ptr_valid, rd_req_ready, cpl_data, cpl_valid, c2f_ready, wr_req_ready,
    output rd_req_valid, rd_req_addr, c2f_data, c2f_valid, wr_req_valid, wr_req_addr, wr_req_data, checksum, rd_ptr
  );
  modport slave(
    output dma_reset, c2f_base, c2f_wr_ptr, c2f_wr_ptr_valid, rd_req_ready, cpl_data, cpl_valid, c2f_ready, wr_req_ready,
    input rd_req_valid, rd_req_addr, c2f_data, c2f_valid, wr_req_valid, wr_req_addr, wr_req_data, checksum, rd_ptr
  );
endinterface

// File: rtl/c2f_dma_reader_fifo.sv
// c2f_dma_reader_fifo: 16x64 sync FIFO (push/push_data in, head/valid out popped on ready, flush, free count out)
module c2f_dma_reader_fifo
  import c2f_dma_reader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  word_t              push_data,
  input  logic               ready,
  output word_t              head,
  output logic               valid,
  output logic [FIFO_AW:0]   free
);
  logic [FIFO_AW-1:0] wr_idx, rd_idx;
  logic [FIFO_AW:0] count;
  logic pop;
  word_t mem [QW_PER_SLOT];
  assign valid = count != '0;
  assign pop = valid && ready;
  assign head = mem[rd_idx];
  assign free = (FIFO_AW+1)'(QW_PER_SLOT) - count;
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= push_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count <= '0;
    end else begin
      wr_idx <= wr_idx + FIFO_AW'(push);
      rd_idx <= rd_idx + FIFO_AW'(pop);
      count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
endmodule

// File: rtl/c2f_dma_reader.sv
// c2f_dma_reader: C2F DMA engine (clk, rst, bus master) - MRd per ring slot, stream completions to app, MWr rd_ptr back, running checksum
module c2f_dma_reader
  import c2f_dma_reader_pkg::*;
(
  input logic clk,
  input logic rst,
  c2f_dma_reader_if.master bus
);
  c2f_state_t state;
  ptr_t wr_ptr, rd_ptr, next_ptr;
  logic [FIFO_AW-1:0] beat;
  logic [FIFO_AW:0] free;
  logic last_beat, push;
  word_t base_addr;
  assign base_addr = word_t'(bus.c2f_base) << 3;
  assign next_ptr = rd_ptr + ptr_t'(1);
  assign last_beat = beat == FIFO_AW'(QW_PER_SLOT - 1);
  assign push = state == CPL && bus.cpl_valid && !bus.dma_reset;
  assign bus.rd_ptr = rd_ptr;
  c2f_dma_reader_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(bus.dma_reset),
    .push(push),
    .push_data(bus.cpl_data),
    .ready(bus.c2f_ready),
    .head(bus.c2f_data),
    .valid(bus.c2f_valid),
    .free(free)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat <= '0;
      bus.checksum <= '0;
      bus.rd_req_valid <= 1'b0;
      bus.rd_req_addr <= '0;
      bus.wr_req_valid <= 1'b0;
      bus.wr_req_addr <= '0;
      bus.wr_req_data <= '0;
    end else if (bus.dma_reset) begin
      wr_ptr <= bus.c2f_wr_ptr_valid ? bus.c2f_wr_ptr : '0;
      rd_ptr <= '0;
      bus.checksum <= '0;
      bus.rd_req_valid <= 1'b0;
      bus.wr_req_valid <= 1'b0;
      state <= (state == REQ && bus.rd_req_ready) ||
               ((state == CPL || state == DRAIN) && !(bus.cpl_valid && last_beat)) ? DRAIN : IDLE;
      beat <= state == REQ ? '0 : beat + FIFO_AW'(bus.cpl_valid);
    end else begin
      if (bus.c2f_wr_ptr_valid) wr_ptr <= bus.c2f_wr_ptr;
      case (state)
        IDLE:
          if (rd_ptr != wr_ptr && free >= (FIFO_AW+1)'(QW_PER_SLOT)) begin
            state <= REQ;
            bus.rd_req_valid <= 1'b1;
            bus.rd_req_addr <= base_addr + (word_t'(rd_ptr) << SLOT_BYTES_LOG2);
          end
        REQ:
          if (bus.rd_req_ready) begin
            state <= CPL;
            bus.rd_req_valid <= 1'b0;
            beat <= '0;
          end
        CPL:
          if (bus.cpl_valid) begin
            bus.checksum <= bus.checksum + bus.cpl_data;
            beat <= beat + FIFO_AW'(1);
            if (last_beat) begin
              rd_ptr <= next_ptr;
              state <= UPD;
              bus.wr_req_valid <= 1'b1;
              bus.wr_req_addr <= base_addr + word_t'(PTR_OFFSET);
              bus.wr_req_data <= word_t'(next_ptr);
            end
          end
        UPD:
          if (bus.wr_req_ready) begin
            state <= IDLE;
            bus.wr_req_valid <= 1'b0;
          end
        DRAIN:
          if (bus.cpl_valid) begin
            beat <= beat + FIFO_AW'(1);
            if (last_beat) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2f_dma_reader.sv
// tb_c2f_dma_reader: directed + randomized bench with a host/ring reference model for c2f_dma_reader
module tb_c2f_dma_reader;
  import c2f_dma_reader_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  c2f_dma_reader_if bus();
  c2f_dma_reader dut (.clk(clk), .rst(rst), .bus(bus.master));
  int checks = 0;
  int errors = 0;
  word_t cpl_q[$], exp_stream[$], got_stream[$], exp_mrd[$], got_mrd[$];
  word_t exp_mwa[$], exp_mwd[$], got_mwa[$], got_mwd[$];
  word_t exp_sum = '0;
  int mdl_rd = 0;
  int beats_sent = 0;
  logic [31:0] base;
  bit seq_mode = 1'b1;
  bit cpl_pause = 1'b0;
  int rd_rdy_mode = 1, wr_rdy_mode = 1, app_rdy_mode = 1, gap_pct = 0;

  function automatic logic drive_mode(int m);
    return m == 2 ? 1'($urandom_range(0, 1)) : (m == 1);
  endfunction

  function automatic word_t seq64(int i);
    return 64'h0101_0101_0101_0101 * word_t'(i + 1);
  endfunction

  task automatic chk(string tag, word_t got, word_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.rd_req_valid && bus.rd_req_ready) begin
      got_mrd.push_back(bus.rd_req_addr);
      for (int i = 0; i < QW_PER_SLOT; i++) begin
        word_t d = seq_mode ? seq64(i) : {$urandom, $urandom};
        cpl_q.push_back(d);
        exp_stream.push_back(d);
        exp_sum += d;
      end
    end
    if (bus.c2f_valid && bus.c2f_ready) got_stream.push_back(bus.c2f_data);
    if (bus.wr_req_valid && bus.wr_req_ready) begin
      got_mwa.push_back(bus.wr_req_addr);
      got_mwd.push_back(bus.wr_req_data);
    end
    @(posedge clk);
    #1;
    bus.c2f_wr_ptr_valid = 1'b0;
    bus.dma_reset = 1'b0;
    bus.cpl_valid = 1'b0;
    if (!cpl_pause && cpl_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      bus.cpl_valid = 1'b1;
      bus.cpl_data = cpl_q.pop_front();
      beats_sent++;
    end
    bus.rd_req_ready = drive_mode(rd_rdy_mode);
    bus.wr_req_ready = drive_mode(wr_rdy_mode);
    bus.c2f_ready = drive_mode(app_rdy_mode);
  endtask

  task automatic host_write(int p);
    bus.c2f_wr_ptr = ptr_t'(p);
    bus.c2f_wr_ptr_valid = 1'b1;
    for (int s = mdl_rd; s != p; s = (s + 1) % 16) begin
      exp_mrd.push_back(word_t'(base) * 8 + word_t'(s) * 128);
      exp_mwa.push_back(word_t'(base) * 8 + word_t'(PTR_OFFSET));
      exp_mwd.push_back(word_t'((s + 1) % 16));
    end
    mdl_rd = p;
    tick();
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (n < budget && !(cpl_q.size() == 0 && got_mwa.size() >= exp_mwa.size() &&
           got_stream.size() >= exp_stream.size() && !bus.wr_req_valid && !bus.rd_req_valid)) begin
      tick();
      n++;
    end
    chk({tag, "_in_budget"}, word_t'(n < budget), 1);
  endtask

  task automatic compare_all(string tag);
    chk({tag, "_mrd_n"}, word_t'(got_mrd.size()), word_t'(exp_mrd.size()));
    for (int i = 0; i < got_mrd.size() && i < exp_mrd.size(); i++)
      chk($sformatf("%s_mrd%0d", tag, i), got_mrd[i], exp_mrd[i]);
    chk({tag, "_mwr_n"}, word_t'(got_mwa.size()), word_t'(exp_mwa.size()));
    for (int i = 0; i < got_mwa.size() && i < exp_mwa.size(); i++) begin
      chk($sformatf("%s_mwa%0d", tag, i), got_mwa[i], exp_mwa[i]);
      chk($sformatf("%s_mwd%0d", tag, i), got_mwd[i], exp_mwd[i]);
    end
    chk({tag, "_qw_n"}, word_t'(got_stream.size()), word_t'(exp_stream.size()));
    for (int i = 0; i < got_stream.size() && i < exp_stream.size(); i++)
      chk($sformatf("%s_qw%0d", tag, i), got_stream[i], exp_stream[i]);
    chk({tag, "_checksum"}, bus.checksum, exp_sum);
    chk({tag, "_rd_ptr"}, word_t'(bus.rd_ptr), word_t'(mdl_rd));
    got_mrd.delete(); exp_mrd.delete();
    got_mwa.delete(); exp_mwa.delete();
    got_mwd.delete(); exp_mwd.delete();
    got_stream.delete(); exp_stream.delete();
  endtask

  task automatic abort_model();
    exp_stream.delete();
    exp_mwa.delete();
    exp_mwd.delete();
    exp_sum = '0;
    mdl_rd = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    base = 32'h20;
    bus.dma_reset = 1'b0;
    bus.c2f_base = base;
    bus.c2f_wr_ptr = '0;
    bus.c2f_wr_ptr_valid = 1'b0;
    bus.rd_req_ready = 1'b1;
    bus.wr_req_ready = 1'b1;
    bus.c2f_ready = 1'b1;
    bus.cpl_valid = 1'b0;
    bus.cpl_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rd_valid", word_t'(bus.rd_req_valid), 0);
    chk("rst_wr_valid", word_t'(bus.wr_req_valid), 0);
    chk("rst_c2f_valid", word_t'(bus.c2f_valid), 0);
    chk("rst_rd_addr", bus.rd_req_addr, 0);
    chk("rst_wr_addr", bus.wr_req_addr, 0);
    chk("rst_wr_data", bus.wr_req_data, 0);
    chk("rst_checksum", bus.checksum, 0);
    chk("rst_rd_ptr", word_t'(bus.rd_ptr), 0);

    host_write(0);
    repeat (100) tick();
    compare_all("equal");

    host_write(1);
    wait_done("slot1", 300);
    compare_all("slot1");

    seq_mode = 1'b0;
    gap_pct = 30;
    rd_rdy_mode = 2; wr_rdy_mode = 2; app_rdy_mode = 2;
    base = $urandom & 32'h0fff_ffff;
    bus.c2f_base = base;
    host_write(15);
    wait_done("rand", 6000);
    compare_all("rand");
    base = 32'h20;
    bus.c2f_base = base;
    host_write(1);
    wait_done("wrap", 1500);
    compare_all("wrap");

    gap_pct = 0;
    rd_rdy_mode = 1; wr_rdy_mode = 1; app_rdy_mode = 0;
    host_write(3);
    repeat (100) tick();
    chk("stall_mrd_n", word_t'(got_mrd.size()), 1);
    chk("stall_mwr_n", word_t'(got_mwa.size()), 1);
    chk("stall_qw_n", word_t'(got_stream.size()), 0);
    chk("stall_c2f_valid", word_t'(bus.c2f_valid), 1);
    app_rdy_mode = 1;
    wait_done("stall", 300);
    compare_all("stall");

    app_rdy_mode = 0;
    beats_sent = 0;
    host_write(4);
    n = 0;
    while (beats_sent < 5 && n < 200) begin tick(); n++; end
    chk("abort_5_beats", word_t'(beats_sent), 5);
    cpl_pause = 1'b1;
    tick();
    bus.dma_reset = 1'b1;
    tick();
    abort_model();
    cpl_pause = 1'b0;
    repeat (40) tick();
    app_rdy_mode = 1;
    repeat (20) tick();
    compare_all("abort");
    bus.dma_reset = 1'b1;
    host_write(1);
    wait_done("restart", 300);
    compare_all("restart");

    rd_rdy_mode = 0; wr_rdy_mode = 0;
    host_write(2);
    n = 0;
    while (!bus.rd_req_valid && n < 20) begin tick(); n++; end
    chk("hold_mrd_seen", word_t'(bus.rd_req_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_rd_valid", word_t'(bus.rd_req_valid), 1);
      chk("hold_rd_addr", bus.rd_req_addr, word_t'(base) * 8 + 128);
      tick();
    end
    rd_rdy_mode = 1;
    n = 0;
    while (!bus.wr_req_valid && n < 100) begin tick(); n++; end
    chk("hold_mwr_seen", word_t'(bus.wr_req_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_wr_valid", word_t'(bus.wr_req_valid), 1);
      chk("hold_wr_addr", bus.wr_req_addr, word_t'(base) * 8 + word_t'(PTR_OFFSET));
      chk("hold_wr_data", bus.wr_req_data, 2);
      tick();
    end
    wr_rdy_mode = 1;
    wait_done("hold", 300);
    compare_all("hold");

    app_rdy_mode = 0;
    beats_sent = 0;
    host_write(3);
    n = 0;
    while (beats_sent < 3 && n < 200) begin tick(); n++; end
    cpl_pause = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    abort_model();
    cpl_pause = 1'b0;
    repeat (40) tick();
    app_rdy_mode = 1;
    repeat (20) tick();
    compare_all("hard_rst");
    host_write(1);
    wait_done("post_rst", 300);
    compare_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c2f_dma_reader.md
Name: c2f_dma_reader

Overview:
- FPGA-side engine for the CPU-to-FPGA (C2F) DMA channel. It is the responder to the host driver's C2F_BASE / C2F_WRPTR register writes.
- Host fills 128-byte slots in a 16-slot circular buffer. For each slot, the engine issues one MRd, streams the completion data to the application, then posts its updated read pointer back to host memory with an MWr.
- Sits between the tlp_xcvr register decode / TLP mux and the application's C2F consumer. It also keeps a running 64-bit checksum that software reads through registers 254/255.

Parameters:
- SLOT_LOG2, 4, log2 of slots in host ring (16 slots).
- QW_PER_SLOT, 16, 64-bit words per slot (128 bytes, one MRd of 32 DW).
- PTR_OFFSET, 2048, byte offset of read-pointer QW from ring base (= 16*128).

Ports:
- clk_in  in  1  PCIe-domain clock.
- reset_in  in  1  synchronous, active-high reset.
- dmaReset_in  in  1  pulse on DMA_ENABLE register write; soft reset of channel.
- c2fBase_in  in  32  ring base as host QW address (byte address = value*8); sampled when a request is built.
- c2fWrPtr_in  in  SLOT_LOG2  host write pointer.
- c2fWrPtrValid_in  in  1  pulse when C2F_WRPTR register written.
- rdReqValid_out / rdReqReady_in  out/in  1  MRd request handshake.
- rdReqAddr_out  out  64  MRd byte address; length fixed 32 DW.
- cplData_in  in  64  completion payload QW.
- cplValid_in  in  1  completion QW valid; no backpressure.
- c2fData_out  out  64  QW to application.
- c2fValid_out / c2fReady_in  out/in  1  app stream handshake.
- wrReqValid_out / wrReqReady_in  out/in  1  MWr request handshake.
- wrReqAddr_out  out  64  MWr byte address.
- wrReqData_out  out  64  MWr payload (zero-extended rdPtr).
- checksum_out  out  64  sum mod 2^64 of all QWs accepted from completions.
- rdPtr_out  out  SLOT_LOG2  current internal read pointer.

Behaviour:
- Reset (reset_in high at a clock edge) clears:
  - wrPtr, rdPtr and checksum to 0;
  - FSM to IDLE;
  - all valid outputs to 0, address/data outputs to 0;
  - the FIFO.
- Register capture: on c2fWrPtrValid_in, wrPtr <= c2fWrPtr_in. Latest write wins; the FSM sees it next cycle.
- FSM states: IDLE, REQ, CPL, UPD, DRAIN.
- IDLE:
  - If rdPtr != wrPtr and FIFO free count >= QW_PER_SLOT, go to REQ.
  - rdReqAddr_out <= c2fBase_in*8 + rdPtr*128, and rdReqValid_out is asserted the next cycle.
- REQ: hold rdReqValid_out/rdReqAddr_out stable until rdReqReady_in. Then deassert, clear beat counter, go to CPL.
- CPL:
  - Each cplValid_in pushes cplData_in into the FIFO and adds it to the checksum, both in the same cycle.
  - After QW_PER_SLOT beats, rdPtr <= rdPtr+1 (wraps 15 -> 0), then go to UPD.
- UPD:
  - wrReqValid_out asserted with wrReqAddr_out = c2fBase_in*8 + PTR_OFFSET and wrReqData_out = new rdPtr. Hold until wrReqReady_in.
  - Then go to IDLE; back-to-back slots proceed without host intervention.
- Output stream: FIFO head drives c2fData_out/c2fValid_out. Pop on valid & ready. FIFO write-to-read latency is 1 cycle.
- Only one MRd is outstanding at a time. The FIFO never overflows because a request needs >= 16 free entries.
- dmaReset_in, in any state:
  - wrPtr, rdPtr and checksum cleared, FIFO flushed.
  - REQ or UPD: drop valid, go to IDLE. An accepted-cycle handshake still counts as issued: if REQ was accepted in the same cycle, go to DRAIN.
  - CPL: go to DRAIN.
  - DRAIN consumes the remaining beats of the outstanding completion without pushing to the FIFO or touching the checksum, then goes to IDLE.
- dmaReset_in and c2fWrPtrValid_in in the same cycle: reset first, then wrPtr <= c2fWrPtr_in.
- reset_in overrides everything; any in-flight completion beats after reset are ignored (no DRAIN).

Decomposition:
- Shared package (tlp_xcvr_pkg): C2F_BASE, C2F_WRPTR, DMA_ENABLE register indices; QW_PER_SLOT; PTR_OFFSET; a C2fState enum typedef; the 64-bit word type.
- One sub-module: c2f_fifo, a 16x64 synchronous FIFO with free-count output.

Test Plan:
- Base 0x20, wrPtr 1, completion SEQ64[0..15], c2fReady_in=1 -> one MRd @0x100; 16 QWs forwarded in order; MWr @0x900 data 1; checksum = sum SEQ64[0..15]; rdPtr_out=1.
- wrPtr written equal to rdPtr (0) -> no MRd, no MWr, outputs remain idle for 100 cycles.
- Preload rdPtr=15 (15 slots), write wrPtr=1 -> MRd @0x880 then @0x100; MWr data 0 then 1; rdPtr wraps to 1.
- wrPtr=2, c2fReady_in=0 -> first slot fills FIFO (16 entries); second MRd not issued until 16 pops with ready=1.
- dmaReset_in after 5 of 16 beats -> 11 remaining beats discarded; no MWr; checksum 0, rdPtr 0; a fresh wrPtr=1 then yields a clean MRd @base.
- rdReqReady_in and wrReqReady_in held low 10 cycles -> valid, address and data stay stable until accepted.
